// File: rtl/uart_alu_ctrl_pkg.sv
// Shared types and helpers for the UART/ALU sequencer.
// Defines the one-hot state encoding, the default byte width and a ceil-log2 helper.
package uart_alu_ctrl_pkg;

  localparam int unsigned DEF_DATA_BITS = 8;

  typedef enum logic [5:0] {
    WAIT_A  = 6'b000001,
    WAIT_B  = 6'b000010,
    WAIT_OP = 6'b000100,
    EXEC    = 6'b001000,
    START   = 6'b010000,
    WAIT_TX = 6'b100000
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (value > (32'd1 << i)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the receiver, ALU and transmitter signals around the sequencer.
// The master modport is the sequencer; the slave modport is its surroundings.
interface uart_alu_ctrl_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OP_BITS   = 6
);
  logic                 rx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic [DATA_BITS-1:0] alu_result;
  logic                 tx_done;
  logic [DATA_BITS-1:0] alu_a;
  logic [DATA_BITS-1:0] alu_b;
  logic [OP_BITS-1:0]   alu_op;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 busy;
  logic                 timeout;
  logic                 overrun;

  modport master (
    input  rx_done, rx_data, alu_result, tx_done,
    output alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, overrun
  );

  modport slave (
    output rx_done, rx_data, alu_result, tx_done,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout, overrun
  );
endinterface

// File: rtl/uart_alu_ctrl_rise_detect.sv
// Rising-edge detector for level-style done flags.
// A level held high produces a single pulse in the cycle it first appears.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

  assign pulse = d & ~q;
endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer: gathers operand A, operand B and opcode from the UART receiver,
// drives the ALU, hands the result to the transmitter and waits for completion.
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
  parameter int unsigned OP_BITS        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  uart_alu_ctrl_if.master bus
);

  localparam int unsigned TIMER_W = clog2(TIMEOUT_CYCLES);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic                 rx_ev;
  logic                 tx_ev;
  logic                 expired;
  logic                 counting;

  logic [DATA_BITS-1:0] alu_a_r;
  logic [DATA_BITS-1:0] alu_b_r;
  logic [OP_BITS-1:0]   alu_op_r;
  logic [DATA_BITS-1:0] tx_data_r;
  logic                 tx_start_r;
  logic                 busy_r;
  logic                 timeout_r;
  logic                 overrun_r;

  rise_detect u_rx_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx_done),
    .pulse (rx_ev)
  );

  rise_detect u_tx_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.tx_done),
    .pulse (tx_ev)
  );

  assign expired  = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  // A byte arriving on the expiry cycle wins, so the timer only runs while idle between bytes.
  assign counting = ((state == WAIT_B) || (state == WAIT_OP)) && !rx_ev && !expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (counting) begin
      timer <= (timer == '1) ? timer : timer + TIMER_W'(1);
    end else begin
      timer <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_A;
      alu_a_r    <= '0;
      alu_b_r    <= '0;
      alu_op_r   <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      timeout_r  <= 1'b0;
      overrun_r  <= 1'b0;
      case (state)
        WAIT_A: begin
          if (rx_ev) begin
            alu_a_r <= bus.rx_data;
            state   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_ev) begin
            alu_b_r <= bus.rx_data;
            state   <= WAIT_OP;
          end else if (expired) begin
            timeout_r <= 1'b1;
            state     <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (rx_ev) begin
            alu_op_r <= bus.rx_data[OP_BITS-1:0];
            busy_r   <= 1'b1;
            state    <= EXEC;
          end else if (expired) begin
            timeout_r <= 1'b1;
            state     <= WAIT_A;
          end
        end
        EXEC: begin
          overrun_r <= rx_ev;
          tx_data_r <= bus.alu_result;
          state     <= START;
        end
        START: begin
          // Registered pulse: visible in the first WAIT_TX cycle.
          overrun_r  <= rx_ev;
          tx_start_r <= 1'b1;
          state      <= WAIT_TX;
        end
        WAIT_TX: begin
          overrun_r <= rx_ev;
          if (tx_ev) begin
            busy_r <= 1'b0;
            state  <= WAIT_A;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= WAIT_A;
        end
      endcase
    end
  end

  assign bus.alu_a    = alu_a_r;
  assign bus.alu_b    = alu_b_r;
  assign bus.alu_op   = alu_op_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;
  assign bus.busy     = busy_r;
  assign bus.timeout  = timeout_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small ADD/SUB ALU model (op 0x20 adds).
// Expected values are hand-computed per vector.
module tb_uart_alu_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   n_start;
  int   n_to;
  int   n_ov;
  int   s0;

  uart_alu_ctrl_if #(.DATA_BITS(8), .OP_BITS(6)) bus ();

  uart_alu_ctrl #(
    .DATA_BITS      (8),
    .OP_BITS        (6),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.alu_result = (bus.alu_op == 6'h20) ? bus.alu_a + bus.alu_b : bus.alu_a - bus.alu_b;
  end

  always @(negedge clk) begin
    if (bus.tx_start) n_start++;
    if (bus.timeout)  n_to++;
    if (bus.overrun)  n_ov++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic send_hold(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(posedge clk); #1;
    bus.tx_done = 1'b1;
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=expired exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; n_start = 0; n_to = 0; n_ov = 0;
    reset = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    bus.tx_done = 1'b0;
    #3;
    check_eq("rst_alu_a", bus.alu_a, 8'h00);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_tx_start", bus.tx_start, 1'b0);
    check_eq("rst_tx_data", bus.tx_data, 8'h00);
    @(negedge clk); reset = 1'b0;

    // 1: basic ADD frame and tx_start latency
    send_byte(8'h05);
    send_byte(8'h03);
    s0 = n_start;
    send_byte(8'h20);
    check_eq("t1_alu_a", bus.alu_a, 8'h05);
    check_eq("t1_alu_b", bus.alu_b, 8'h03);
    check_eq("t1_alu_op", bus.alu_op, 6'h20);
    check_eq("t1_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    check_eq("t1_tx_data", bus.tx_data, 8'h08);
    check_eq("t1_start_early", bus.tx_start, 1'b0);
    @(posedge clk); #1;
    check_eq("t1_start", bus.tx_start, 1'b1);
    @(posedge clk); #1;
    check_eq("t1_start_end", bus.tx_start, 1'b0);
    check_eq("t1_start_cnt", n_start - s0, 1);
    tx_done_pulse();
    check_eq("t1_busy_clr", bus.busy, 1'b0);

    // 2: rx_done held high across many cycles counts once
    s0 = n_start;
    begin
      int ov0;
      ov0 = n_ov;
      send_hold(8'h0A, 12);
      send_hold(8'h04, 12);
      send_hold(8'h21, 12);
      check_eq("t2_alu_a", bus.alu_a, 8'h0A);
      check_eq("t2_alu_b", bus.alu_b, 8'h04);
      check_eq("t2_alu_op", bus.alu_op, 6'h21);
      check_eq("t2_tx_data", bus.tx_data, 8'h06);
      check_eq("t2_overrun_cnt", n_ov - ov0, 0);
      check_eq("t2_start_cnt", n_start - s0, 1);
      check_eq("t2_busy", bus.busy, 1'b1);
    end
    tx_done_pulse();
    check_eq("t2_busy_clr", bus.busy, 1'b0);

    // 3: timeout after a lone operand, then a fresh frame
    s0 = n_to;
    send_byte(8'h11);
    repeat (15) @(posedge clk);
    #1;
    check_eq("t3_no_to_yet", bus.timeout, 1'b0);
    @(posedge clk); #1;
    check_eq("t3_timeout", bus.timeout, 1'b1);
    check_eq("t3_keep_a", bus.alu_a, 8'h11);
    check_eq("t3_keep_b", bus.alu_b, 8'h04);
    @(posedge clk); #1;
    check_eq("t3_to_end", bus.timeout, 1'b0);
    check_eq("t3_to_cnt", n_to - s0, 1);
    send_byte(8'h07);
    send_byte(8'h02);
    send_byte(8'h20);
    check_eq("t3_new_a", bus.alu_a, 8'h07);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t3_tx_data", bus.tx_data, 8'h09);
    check_eq("t3_start", bus.tx_start, 1'b1);
    tx_done_pulse();

    // 4: overrun while waiting for transmit completion
    send_byte(8'h30);
    send_byte(8'h10);
    send_byte(8'h01);
    repeat (2) @(posedge clk);
    s0 = n_ov;
    send_byte(8'h55);
    check_eq("t4_overrun", bus.overrun, 1'b1);
    check_eq("t4_busy", bus.busy, 1'b1);
    check_eq("t4_keep_a", bus.alu_a, 8'h30);
    check_eq("t4_tx_data", bus.tx_data, 8'h20);
    @(posedge clk); #1;
    check_eq("t4_ov_end", bus.overrun, 1'b0);
    check_eq("t4_ov_cnt", n_ov - s0, 1);
    tx_done_pulse();
    check_eq("t4_busy_clr", bus.busy, 1'b0);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h20);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t4_rearm_tx", bus.tx_data, 8'h05);
    tx_done_pulse();

    // 5: asynchronous reset in WAIT_OP and in WAIT_TX
    send_byte(8'h01);
    send_byte(8'h02);
    s0 = n_start;
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_eq("t5_op_rst_a", bus.alu_a, 8'h00);
    check_eq("t5_op_rst_b", bus.alu_b, 8'h00);
    @(negedge clk); reset = 1'b0;
    send_byte(8'h03);
    check_eq("t5_restart_a", bus.alu_a, 8'h03);
    check_eq("t5_restart_busy", bus.busy, 1'b0);
    repeat (10) @(posedge clk);
    check_eq("t5_no_start1", n_start - s0, 0);
    send_byte(8'h04);
    send_byte(8'h20);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_busy_tx", bus.busy, 1'b1);
    s0 = n_start;
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5_tx_rst_busy", bus.busy, 1'b0);
    check_eq("t5_tx_rst_data", bus.tx_data, 8'h00);
    check_eq("t5_tx_rst_op", bus.alu_op, 6'h00);
    @(negedge clk); reset = 1'b0;
    repeat (20) @(posedge clk);
    check_eq("t5_no_start2", n_start - s0, 0);

    // 6: opcode arriving on the expiry cycle is accepted
    send_byte(8'h40);
    send_byte(8'h08);
    s0 = n_to;
    repeat (14) @(posedge clk);
    send_byte(8'h20);
    check_eq("t6_timeout", bus.timeout, 1'b0);
    check_eq("t6_busy", bus.busy, 1'b1);
    check_eq("t6_alu_op", bus.alu_op, 6'h20);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_tx_data", bus.tx_data, 8'h48);
    check_eq("t6_to_cnt", n_to - s0, 0);
    tx_done_pulse();
    check_eq("t6_busy_clr", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
